// File: rtl/ika9958_cpu_regwr.sv
// ika9958_cpu_regwr: V9958 CPU-side register writer (port #1 byte pairs, port #3 indirect via R#17).
// Optional IKA9958_REG_WRITE_MASK_EN drops writes to unimplemented register slots.
module ika9958_cpu_regwr #(
    parameter int REG_COUNT = 64,
    parameter int R17_IDX   = 17
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST_n,
    input  logic                     i_CS_n,
    input  logic                     i_WR_n,
    input  logic                     i_RD_n,
    input  logic [1:0]               i_MODE,
    input  logic [7:0]               i_DB,
    output logic [8*REG_COUNT-1:0]   o_REG_ARR,
    output logic                     o_REG_WE,
    output logic [5:0]               o_REG_WADDR,
    output logic                     o_VADDR_WE,
    output logic [13:0]              o_VADDR,
    output logic                     o_VADDR_RD,
    output logic                     o_FF
);

    typedef enum logic {ST_IDLE = 1'b0, ST_HAVE1 = 1'b1} state_t;

    localparam logic [5:0] R17_A = 6'(R17_IDX);

`ifdef IKA9958_REG_WRITE_MASK_EN
    // Slots 24, 28-31 and 47-63 do not exist on the V9958.
    localparam logic [63:0] WR_MASK = 64'h0000_7FFF_0EFF_FFFF;
`else
    localparam logic [63:0] WR_MASK = '1;
`endif

    state_t     r_state;
    logic [7:0] r_regs [REG_COUNT];
    logic       r_wr_act;
    logic       r_rd_act;
    logic [7:0] r_db;
    logic [1:0] r_mode;
    logic [7:0] r_latch;
    logic       r_reg_we;
    logic [5:0] r_reg_waddr;
    logic       r_vaddr_we;
    logic [13:0] r_vaddr;
    logic       r_vaddr_rd;

    logic       w_wr_act;
    logic       w_rd_act;
    logic       w_wr_commit;
    logic       w_rd_commit;
    logic [5:0] w_ptr;
    logic       w_p1_ok;
    logic       w_p3_ok;

    assign w_wr_act    = ~i_CS_n & ~i_WR_n;
    assign w_rd_act    = ~i_CS_n & ~i_RD_n & i_WR_n;
    // Commit on the first inactive cycle so one strobe yields one commit regardless of length.
    assign w_wr_commit = r_wr_act & ~w_wr_act;
    assign w_rd_commit = r_rd_act & ~w_rd_act;
    assign w_ptr       = r_regs[R17_A][5:0];
    assign w_p1_ok     = WR_MASK[r_db[5:0]];
    assign w_p3_ok     = WR_MASK[w_ptr] && (w_ptr != R17_A);

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state     <= ST_IDLE;
            // NOTE: the register file is reset slot by slot; it feeds mode decoding and must start known.
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
            r_wr_act    <= 1'b0;
            r_rd_act    <= 1'b0;
            r_db        <= '0;
            r_mode      <= '0;
            r_latch     <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_vaddr_we  <= 1'b0;
            r_vaddr     <= '0;
            r_vaddr_rd  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge state (e.g. R#17 pointer).
            r_reg_we   <= 1'b0;
            r_vaddr_we <= 1'b0;
            r_wr_act   <= w_wr_act;
            r_rd_act   <= w_rd_act;
            if (w_wr_act) r_db <= i_DB;
            if (w_wr_act || w_rd_act) r_mode <= i_MODE;

            if (w_wr_commit) begin
                case (r_mode)
                    2'd1: begin
                        if (r_state == ST_IDLE) begin
                            r_latch <= r_db;
                            r_state <= ST_HAVE1;
                        end else begin
                            r_state <= ST_IDLE;
                            if (r_db[7]) begin
                                if (w_p1_ok) begin
                                    r_regs[r_db[5:0]] <= r_latch;
                                    r_reg_we          <= 1'b1;
                                    r_reg_waddr       <= r_db[5:0];
                                end
                            end else begin
                                r_vaddr    <= {r_db[5:0], r_latch};
                                r_vaddr_rd <= ~r_db[6];
                                r_vaddr_we <= 1'b1;
                            end
                        end
                    end
                    2'd3: begin
                        if (w_p3_ok) begin
                            r_regs[w_ptr] <= r_db;
                            r_reg_we      <= 1'b1;
                            r_reg_waddr   <= w_ptr;
                        end
                        if (!r_regs[R17_A][7]) r_regs[R17_A][5:0] <= 6'(w_ptr + 6'd1);
                    end
                    default: ;
                endcase
            end else if (w_rd_commit && r_mode == 2'd1) begin
                r_state <= ST_IDLE;
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign o_REG_ARR[8*g +: 8] = r_regs[g];
    end

    assign o_REG_WE    = r_reg_we;
    assign o_REG_WADDR = r_reg_waddr;
    assign o_VADDR_WE  = r_vaddr_we;
    assign o_VADDR     = r_vaddr;
    assign o_VADDR_RD  = r_vaddr_rd;
    assign o_FF        = (r_state == ST_HAVE1);

endmodule

// File: tb/tb_ika9958_cpu_regwr.sv
// Self-checking bench for ika9958_cpu_regwr: directed test-plan steps plus randomized
// CPU port traffic checked against a transaction-level model of the register file.
module tb_ika9958_cpu_regwr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cs_n, wr_n, rd_n;
    logic [1:0]   mode;
    logic [7:0]   db;
    logic [511:0] reg_arr;
    logic         reg_we;
    logic [5:0]   reg_waddr;
    logic         vaddr_we;
    logic [13:0]  vaddr;
    logic         vaddr_rd;
    logic         ff;

    always #5 clk = ~clk;

    ika9958_cpu_regwr dut (
        .i_EMUCLK   (clk),
        .i_RST_n    (rst_n),
        .i_CS_n     (cs_n),
        .i_WR_n     (wr_n),
        .i_RD_n     (rd_n),
        .i_MODE     (mode),
        .i_DB       (db),
        .o_REG_ARR  (reg_arr),
        .o_REG_WE   (reg_we),
        .o_REG_WADDR(reg_waddr),
        .o_VADDR_WE (vaddr_we),
        .o_VADDR    (vaddr),
        .o_VADDR_RD (vaddr_rd),
        .o_FF       (ff)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [7:0]  m_regs [64];
    logic        m_ff;
    logic [7:0]  m_latch;
    logic [5:0]  exp_waddr;
    logic [13:0] exp_vaddr;
    logic        exp_vrd;
    int          exp_we_cnt = 0;
    int          exp_vwe_cnt = 0;

    // Observed pulse counts
    int          obs_we_cnt = 0;
    int          obs_vwe_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we === 1'b1) obs_we_cnt++;
            if (vaddr_we === 1'b1) obs_vwe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_writable(input int idx);
`ifdef IKA9958_REG_WRITE_MASK_EN
        return !(idx == 24 || (idx >= 28 && idx <= 31) || idx >= 47);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [511:0] m_flat();
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_ff      = 1'b0;
        m_latch   = 8'h00;
        exp_waddr = 6'd0;
        exp_vaddr = 14'd0;
        exp_vrd   = 1'b0;
    endtask

    task automatic m_write(input logic [1:0] p, input logic [7:0] b);
        int t;
        if (p == 2'd1) begin
            if (!m_ff) begin
                m_latch = b;
                m_ff    = 1'b1;
            end else begin
                m_ff = 1'b0;
                if (b[7]) begin
                    if (m_writable(int'(b[5:0]))) begin
                        m_regs[b[5:0]] = m_latch;
                        exp_we_cnt++;
                        exp_waddr = b[5:0];
                    end
                end else begin
                    exp_vaddr = {b[5:0], m_latch};
                    exp_vrd   = !b[6];
                    exp_vwe_cnt++;
                end
            end
        end else if (p == 2'd3) begin
            t = int'(m_regs[17][5:0]);
            if (t != 17 && m_writable(t)) begin
                m_regs[t] = b;
                exp_we_cnt++;
                exp_waddr = 6'(t);
            end
            if (!m_regs[17][7]) m_regs[17][5:0] = 6'((t + 1) % 64);
        end
    endtask

    // Strobe held 1-3 cycles; earlier cycles carry junk so only the last value may count.
    task automatic cpu_write(input logic [1:0] p, input logic [7:0] b);
        int len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            wr_n = 1'b0;
            mode = (i == len - 1) ? p : 2'($urandom_range(0, 3));
            db   = (i == len - 1) ? b : 8'($urandom);
        end
        @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        db   = 8'($urandom);
        m_write(p, b);
    endtask

    task automatic cpu_read(input logic [1:0] p);
        int len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            rd_n = 1'b0;
            mode = (i == len - 1) ? p : 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        cs_n = 1'b1;
        rd_n = 1'b1;
        if (p == 2'd1) m_ff = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".regs"},   reg_arr, m_flat());
        check({tag, ".ff"},     512'(ff), 512'(m_ff));
        check({tag, ".wecnt"},  512'(obs_we_cnt), 512'(exp_we_cnt));
        check({tag, ".vwecnt"}, 512'(obs_vwe_cnt), 512'(exp_vwe_cnt));
        check({tag, ".waddr"},  512'(reg_waddr), 512'(exp_waddr));
        check({tag, ".vaddr"},  512'({vaddr_rd, vaddr}), 512'({exp_vrd, exp_vaddr}));
    endtask

    initial begin
        int n_ops;
        int r;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        mode  = 2'd0;
        db    = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst.regs", reg_arr, 512'd0);
        check("rst.ff", 512'(ff), 512'd0);
        check("rst.pulses", 512'({reg_we, vaddr_we}), 512'd0);
        check("rst.outs", 512'({reg_waddr, vaddr_rd, vaddr}), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register write via port #1, with exact pulse timing
        cpu_write(2'd1, 8'h06);
        settle();
        check("p1.first.ff", 512'(ff), 512'd1);
        cpu_write(2'd1, 8'h80);
        @(negedge clk);
        #1;
        check("p1.pulse_hi", 512'(reg_we), 512'd1);
        check("p1.r0_at_pulse", 512'(reg_arr[7:0]), 512'h06);
        @(negedge clk);
        #1;
        check("p1.pulse_lo", 512'(reg_we), 512'd0);
        check("p1.waddr", 512'(reg_waddr), 512'd0);
        check("p1.ff_back", 512'(ff), 512'd0);
        check_state("p1");

        // VRAM address setup
        cpu_write(2'd1, 8'h34);
        cpu_write(2'd1, 8'h52);
        settle();
        check("va.addr", 512'(vaddr), 512'h1234);
        check("va.rd", 512'(vaddr_rd), 512'd0);
        check_state("va");

        // Port #1 read abandons a half-written pair
        cpu_write(2'd1, 8'hAA);
        cpu_read(2'd1);
        cpu_write(2'd1, 8'h55);
        cpu_write(2'd1, 8'h89);
        settle();
        check("rd.r9", 512'(reg_arr[8*9 +: 8]), 512'h55);
        check_state("rd");

        // Indirect writes with pointer wrap
        cpu_write(2'd1, 8'h3E);
        cpu_write(2'd1, 8'h91);
        cpu_write(2'd3, 8'h11);
        cpu_write(2'd3, 8'h22);
        cpu_write(2'd3, 8'h33);
        settle();
`ifndef IKA9958_REG_WRITE_MASK_EN
        check("ind.r62", 512'(reg_arr[8*62 +: 8]), 512'h11);
        check("ind.r63", 512'(reg_arr[8*63 +: 8]), 512'h22);
`endif
        check("ind.r0", 512'(reg_arr[7:0]), 512'h33);
        check("ind.r17", 512'(reg_arr[8*17 +: 8]), 512'h01);
        check_state("ind");

        // Pointer at R#17 itself, then no-increment mode
        cpu_write(2'd1, 8'h91);
        cpu_write(2'd1, 8'h91);
        cpu_write(2'd3, 8'h77);
        settle();
        check("self.r17", 512'(reg_arr[8*17 +: 8]), 512'h91);
        cpu_write(2'd1, 8'h92);
        cpu_write(2'd1, 8'h91);
        cpu_write(2'd3, 8'h01);
        cpu_write(2'd3, 8'h02);
        settle();
        check("noinc.r18", 512'(reg_arr[8*18 +: 8]), 512'h02);
        check("noinc.r17", 512'(reg_arr[8*17 +: 8]), 512'h92);
        check_state("noinc");

`ifdef IKA9958_REG_WRITE_MASK_EN
        cpu_write(2'd1, 8'hFF);
        cpu_write(2'd1, 8'h98);
        settle();
        check("mask.r24", 512'(reg_arr[8*24 +: 8]), 512'h00);
        check_state("mask");
`endif

        // Randomized traffic in back-to-back bursts
        for (int g = 0; g < 40; g++) begin
            n_ops = $urandom_range(1, 6);
            for (int k = 0; k < n_ops; k++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    cpu_write(r == 0 ? 2'd0 : 2'd2, 8'($urandom));
                    2, 3, 4: cpu_write(2'd1, 8'($urandom));
                    5, 6:    cpu_write(2'd3, 8'($urandom));
                    7:       cpu_read(2'd1);
                    default: cpu_read(2'($urandom_range(0, 3)));
                endcase
            end
            settle();
            check_state($sformatf("rnd%0d", g));
        end

        // Reset in the middle of a port #1 pair
        cpu_write(2'd1, 8'h12);
        settle();
        check("mid.ff_set", 512'(ff), 512'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("mid.regs", reg_arr, 512'd0);
        check("mid.ff", 512'(ff), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_write(2'd1, 8'h85);
        settle();
        check("mid.lone_ff", 512'(ff), 512'd1);
        check_state("mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
